// File: rtl/div_pkg.sv
// Shared encodings and sizing for the iterative 32-bit divider.
package div_pkg;
  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/udiv_iter_32.sv
// Restoring unsigned divider core: one quotient bit per i_step, 33-bit trial subtract.
module udiv_iter_32 #(
  parameter int XLEN  = 32,
  parameter int ITER  = 32,
  parameter int CNT_W = $clog2(ITER)
) (
  input  logic            clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem,
  output logic            o_last
);
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quot;
  logic [XLEN-1:0]  r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_diff;

  // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  assign w_shift = {r_rem, r_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_div  <= i_divisor;
      r_cnt  <= '0;
    end else if (i_step) begin
      if (!w_diff[XLEN]) begin
        r_rem  <= w_diff[XLEN-1:0];
        r_quot <= {r_quot[XLEN-2:0], 1'b1};
      end else begin
        r_rem  <= w_shift[XLEN-1:0];
        r_quot <= {r_quot[XLEN-2:0], 1'b0};
      end
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_quot = r_quot;
  assign o_rem  = r_rem;
  assign o_last = (r_cnt == CNT_W'(ITER - 1));
endmodule

// File: rtl/div_ctrl_32.sv
// RISC-V DIV/DIVU/REM/REMU controller: sign handling, special cases, handshakes.
// Handshakes: a transfer happens on a rising edge where valid && ready; a producer holds
// valid and payload stable until that edge, and flush (below reset) overrides both sides.
module div_ctrl_32 #(
  parameter int XLEN = div_pkg::XLEN,
  parameter int ITER = div_pkg::ITER
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [XLEN-1:0]        req_rs1,
  input  logic [XLEN-1:0]        req_rs2,
  input  logic [4:0]             req_rd,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [XLEN-1:0]        resp_data,
  output logic [4:0]             resp_rd,
  output logic                   busy,
  output div_pkg::div_state_e    dbg_state
);
  import div_pkg::*;

  div_state_e      r_state;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_data;
  logic [4:0]      r_resp_rd;
  logic [4:0]      r_rd;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_signed, w_neg1, w_neg2, w_div_zero, w_ovf, w_special, w_accept;
  logic [XLEN-1:0] w_mag1, w_mag2, w_special_res, w_quot, w_rem, w_result;
  logic            w_last, w_start, w_step;

  assign w_signed   = op_is_signed(req_op);
  assign w_neg1     = w_signed && req_rs1[XLEN-1];
  assign w_neg2     = w_signed && req_rs2[XLEN-1];
  assign w_mag1     = w_neg1 ? -req_rs1 : req_rs1;
  assign w_mag2     = w_neg2 ? -req_rs2 : req_rs2;
  assign w_div_zero = (req_rs2 == '0);
  assign w_ovf      = w_signed && (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2 == '1);
  assign w_special  = w_div_zero || w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = op_is_rem(req_op) ? req_rs1 : '1;
    else
      w_special_res = op_is_rem(req_op) ? '0 : req_rs1;
  end

  assign req_ready = (r_state == S_IDLE) && !flush;
  assign w_accept  = req_valid && req_ready;
  assign w_start   = w_accept && !w_special;
  assign w_step    = (r_state == S_CALC) && !flush;

  udiv_iter_32 #(.XLEN(XLEN), .ITER(ITER)) u_iter (
    .clk        (clk),
    .i_reset    (reset),
    .i_start    (w_start),
    .i_step     (w_step),
    .i_dividend (w_mag1),
    .i_divisor  (w_mag2),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_last     (w_last)
  );

  assign w_result = r_is_rem ? (r_neg_r ? -w_rem : w_rem)
                             : (r_neg_q ? -w_quot : w_quot);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_rd    <= '0;
      r_rd         <= '0;
      r_is_rem     <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
    end else if (flush) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd     <= req_rd;
            r_is_rem <= op_is_rem(req_op);
            r_neg_q  <= w_neg1 ^ w_neg2;
            r_neg_r  <= w_neg1;
            if (w_special) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_special_res;
              r_resp_rd    <= req_rd;
              r_state      <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: if (w_last) r_state <= S_FIX;
        S_FIX: begin
          r_resp_valid <= 1'b1;
          r_resp_data  <= w_result;
          r_resp_rd    <= r_rd;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_rd    = r_resp_rd;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;
endmodule
